// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types and limits for the dpram_pipe RAM.
package dpram_pkg;

    localparam int unsigned MAX_LAT = 16;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    // Map the integer RDW_MODE parameter onto the enum.
    function automatic rdw_mode_e to_rdw_mode(input int mode);
        return (mode != 0) ? RDW_WRITE_FIRST : RDW_READ_FIRST;
    endfunction

endpackage

// File: rtl/dpram_lat_pipe.sv
// dpram_lat_pipe: valid-tagged shift pipeline of LAT stages.
// LAT=0 is a combinational pass-through. Only the valid bits are cleared
// by reset; data stages are free-running and never looked at without valid.
module dpram_lat_pipe
    import dpram_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    if (LAT == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = clk ^ rst_n;
        assign o_valid  = i_valid;
        assign o_data   = i_data;
    end else begin : g_stages
        logic [LAT-1:0]   r_valid;
        logic [WIDTH-1:0] r_data [LAT];

        // Valid tags shift each cycle and are cleared asynchronously.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= '0;
            end else begin
                r_valid[0] <= i_valid;
                for (int unsigned i = 1; i < LAT; i++) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end

        // Data payload shifts alongside the valid tags.
        always_ff @(posedge clk) begin
            r_data[0] <= i_data;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end

        assign o_valid = r_valid[LAT-1];
        assign o_data  = r_data[LAT-1];
    end

endmodule

// File: rtl/dpram_pipe.sv
// dpram_pipe: single-clock true dual-port RAM with per-port read/write
// latency pipelines, valid-tagged read data, port-A priority on same-address
// write collisions and selectable read-during-write behaviour.
// Optional macro DPRAM_COLLISION_FLAG_EN adds the registered coll output.
module dpram_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int RD_LAT_A   = 1,
    parameter int WR_LAT_A   = 1,
    parameter int RD_LAT_B   = 1,
    parameter int WR_LAT_B   = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  rvalid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  rvalid_b
`ifdef DPRAM_COLLISION_FLAG_EN
    ,
    output logic                  coll
`endif
);

    localparam int        DEPTH = 1 << ADDR_WIDTH;
    localparam rdw_mode_e P_RDW = to_rdw_mode(RDW_MODE);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
    } rd_rsp_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    wr_req_t w_wreq_in_a, w_wreq_in_b, w_wreq_a, w_wreq_b;
    logic    w_wvld_a, w_wvld_b;
    logic    w_commit_a, w_commit_b, w_same_addr;

    rd_rsp_t w_rrsp_in_a, w_rrsp_in_b, w_rrsp_a, w_rrsp_b;
    logic    w_rvld_a, w_rvld_b;

    logic [DATA_WIDTH-1:0] r_dout_a, r_dout_b;
    logic                  r_rvalid_a, r_rvalid_b;

    // Write request pipelines: the pipe output is the write committing this edge.
    assign w_wreq_in_a = '{addr: addr_a, data: din_a};
    assign w_wreq_in_b = '{addr: addr_b, data: din_b};

    dpram_lat_pipe #(.WIDTH($bits(wr_req_t)), .LAT(WR_LAT_A - 1)) u_wr_pipe_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (en_a & we_a),
        .i_data  (w_wreq_in_a),
        .o_valid (w_wvld_a),
        .o_data  (w_wreq_a)
    );

    dpram_lat_pipe #(.WIDTH($bits(wr_req_t)), .LAT(WR_LAT_B - 1)) u_wr_pipe_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (en_b & we_b),
        .i_data  (w_wreq_in_b),
        .o_valid (w_wvld_b),
        .o_data  (w_wreq_b)
    );

    // Commit arbitration: port A wins a same-address collision.
    assign w_same_addr = w_wvld_a & w_wvld_b & (w_wreq_a.addr == w_wreq_b.addr);
    assign w_commit_a  = w_wvld_a;
    assign w_commit_b  = w_wvld_b & ~w_same_addr;

    // Array update; a zero-stage write pipe is combinational, so hold off while in reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_commit_a) r_mem[w_wreq_a.addr] <= w_wreq_a.data;
            if (w_commit_b) r_mem[w_wreq_b.addr] <= w_wreq_b.data;
        end
    end

    // Read-during-write select: write-first returns the word committing this edge.
    function automatic logic [DATA_WIDTH-1:0] rdw_select(
        input logic [ADDR_WIDTH-1:0] rd_addr,
        input logic [DATA_WIDTH-1:0] mem_word,
        input logic                  ca,
        input wr_req_t               wa,
        input logic                  cb,
        input wr_req_t               wb
    );
        logic [DATA_WIDTH-1:0] word;
        word = mem_word;
        if (P_RDW == RDW_WRITE_FIRST) begin
            if (ca && (wa.addr == rd_addr))      word = wa.data;
            else if (cb && (wb.addr == rd_addr)) word = wb.data;
        end
        return word;
    endfunction

    assign w_rrsp_in_a.data = rdw_select(addr_a, r_mem[addr_a], w_commit_a, w_wreq_a,
                                         w_commit_b, w_wreq_b);
    assign w_rrsp_in_b.data = rdw_select(addr_b, r_mem[addr_b], w_commit_a, w_wreq_a,
                                         w_commit_b, w_wreq_b);

    // Read pipelines carry RD_LAT-1 stages; the output register is the last stage.
    dpram_lat_pipe #(.WIDTH($bits(rd_rsp_t)), .LAT(RD_LAT_A - 1)) u_rd_pipe_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (en_a & ~we_a),
        .i_data  (w_rrsp_in_a),
        .o_valid (w_rvld_a),
        .o_data  (w_rrsp_a)
    );

    dpram_lat_pipe #(.WIDTH($bits(rd_rsp_t)), .LAT(RD_LAT_B - 1)) u_rd_pipe_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (en_b & ~we_b),
        .i_data  (w_rrsp_in_b),
        .o_valid (w_rvld_b),
        .o_data  (w_rrsp_b)
    );

    // Port A output stage: pulse rvalid, hold data between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_a   <= '0;
            r_rvalid_a <= 1'b0;
        end else begin
            r_rvalid_a <= w_rvld_a;
            if (w_rvld_a) r_dout_a <= w_rrsp_a.data;
        end
    end

    // Port B output stage: pulse rvalid, hold data between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_b   <= '0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_b <= w_rvld_b;
            if (w_rvld_b) r_dout_b <= w_rrsp_b.data;
        end
    end

    assign dout_a   = r_dout_a;
    assign rvalid_a = r_rvalid_a;
    assign dout_b   = r_dout_b;
    assign rvalid_b = r_rvalid_b;

`ifdef DPRAM_COLLISION_FLAG_EN
    logic r_coll;

    // Collision flag: one-cycle pulse after an edge where both ports committed to one address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_coll <= 1'b0;
        else        r_coll <= w_same_addr;
    end

    assign coll = r_coll;
`endif

endmodule

// File: tb/tb_dpram_pipe.sv
// tb_dpram_pipe: directed table-driven bench for dpram_pipe (two configurations).
module tb_dpram_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a [2], we_a [2], en_b [2], we_b [2];
    logic [2:0] addr_a [2], addr_b [2];
    logic [7:0] din_a [2], din_b [2], dout_a [2], dout_b [2];
    logic       rvalid_a [2], rvalid_b [2];
`ifdef DPRAM_COLLISION_FLAG_EN
    logic       coll [2];
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // d0: read-first, RD_LAT_A=3 WR_LAT_A=2 RD_LAT_B=4 WR_LAT_B=2
    dpram_pipe #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3),
        .RD_LAT_A(3), .WR_LAT_A(2), .RD_LAT_B(4), .WR_LAT_B(2), .RDW_MODE(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a[0]), .we_a(we_a[0]), .addr_a(addr_a[0]), .din_a(din_a[0]),
        .dout_a(dout_a[0]), .rvalid_a(rvalid_a[0]),
        .en_b(en_b[0]), .we_b(we_b[0]), .addr_b(addr_b[0]), .din_b(din_b[0]),
        .dout_b(dout_b[0]), .rvalid_b(rvalid_b[0])
`ifdef DPRAM_COLLISION_FLAG_EN
        , .coll(coll[0])
`endif
    );

    // d1: write-first, RD_LAT_A=1 WR_LAT_A=4 RD_LAT_B=1 WR_LAT_B=1
    dpram_pipe #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3),
        .RD_LAT_A(1), .WR_LAT_A(4), .RD_LAT_B(1), .WR_LAT_B(1), .RDW_MODE(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a[1]), .we_a(we_a[1]), .addr_a(addr_a[1]), .din_a(din_a[1]),
        .dout_a(dout_a[1]), .rvalid_a(rvalid_a[1]),
        .en_b(en_b[1]), .we_b(we_b[1]), .addr_b(addr_b[1]), .din_b(din_b[1]),
        .dout_b(dout_b[1]), .rvalid_b(rvalid_b[1])
`ifdef DPRAM_COLLISION_FLAG_EN
        , .coll(coll[1])
`endif
    );

    typedef struct {
        int         d;
        logic       ea, wa;
        logic [2:0] aa;
        logic [7:0] da;
        logic       eb, wb;
        logic [2:0] ab;
        logic [7:0] db;
        logic       xrva;
        logic [7:0] xda;
        logic       xrvb;
        logic [7:0] xdb;
        logic       xcoll;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(int d, int ea, int wa, int aa, int da, int eb, int wb,
                                int ab, int db, int xrva, int xda, int xrvb, int xdb,
                                int xcoll);
        vec_t v;
        v.d = d;
        v.ea = (ea != 0); v.wa = (wa != 0); v.aa = 3'(aa); v.da = 8'(da);
        v.eb = (eb != 0); v.wb = (wb != 0); v.ab = 3'(ab); v.db = 8'(db);
        v.xrva = (xrva != 0); v.xda = 8'(xda);
        v.xrvb = (xrvb != 0); v.xdb = 8'(xdb);
        v.xcoll = (xcoll != 0);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int d, input int ea, input int wa, input int aa, input int da,
                         input int eb, input int wb, input int ab, input int db);
        for (int k = 0; k < 2; k++) begin
            en_a[k] = 1'b0; we_a[k] = 1'b0; addr_a[k] = '0; din_a[k] = '0;
            en_b[k] = 1'b0; we_b[k] = 1'b0; addr_b[k] = '0; din_b[k] = '0;
        end
        en_a[d] = (ea != 0); we_a[d] = (wa != 0); addr_a[d] = 3'(aa); din_a[d] = 8'(da);
        en_b[d] = (eb != 0); we_b[d] = (wb != 0); addr_b[d] = 3'(ab); din_b[d] = 8'(db);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 8 back-to-back writes then 8 back-to-back reads on one port.
    task automatic b2b(input int d, input bit pb, input int base, input int rdlat);
        logic exp_rv, rv;
        logic [7:0] dout;
        for (int i = 0; i < 8; i++) begin
            if (pb) drive(d, 0, 0, 0, 0, 1, 1, i, base + i);
            else    drive(d, 1, 1, i, base + i, 0, 0, 0, 0);
            step();
        end
        for (int j = 0; j < 8 + rdlat; j++) begin
            if (j < 8) begin
                if (pb) drive(d, 0, 0, 0, 0, 1, 0, j, 0);
                else    drive(d, 1, 0, j, 0, 0, 0, 0, 0);
            end else begin
                drive(d, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            step();
            exp_rv = (j >= rdlat - 1) && (j < rdlat + 7);
            rv     = pb ? rvalid_b[d] : rvalid_a[d];
            dout   = pb ? dout_b[d] : dout_a[d];
            chk($sformatf("b2b d%0d p%0d rvalid j%0d", d, pb, j), 64'(rv), 64'(exp_rv));
            if (exp_rv) chk($sformatf("b2b d%0d p%0d dout j%0d", d, pb, j), 64'(dout),
                            64'(base + j - rdlat + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (expected finish before 200000)");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // d0: latency, read-first RDW, collision, disjoint dual writes
        tbl.push_back(mk(0, 1,1,4,'h5A, 1,1,2,'h00, 0,'h00,0,'h00,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    0,'h00,0,'h00,0));
        tbl.push_back(mk(0, 1,0,4,0,    0,0,0,0,    0,'h00,0,'h00,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    0,'h00,0,'h00,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    1,'h5A,0,'h00,0));
        tbl.push_back(mk(0, 1,1,2,'h11, 0,0,0,0,    0,'h5A,0,'h00,0));
        tbl.push_back(mk(0, 0,0,0,0,    1,0,2,0,    0,'h5A,0,'h00,0));
        tbl.push_back(mk(0, 0,0,0,0,    1,0,2,0,    0,'h5A,0,'h00,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    0,'h5A,0,'h00,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    0,'h5A,1,'h00,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    0,'h5A,1,'h11,0));
        tbl.push_back(mk(0, 1,1,7,'hAA, 1,1,7,'hBB, 0,'h5A,0,'h11,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    0,'h5A,0,'h11,1));
        tbl.push_back(mk(0, 1,0,7,0,    1,0,7,0,    0,'h5A,0,'h11,0));
        tbl.push_back(mk(0, 1,1,5,'h55, 1,1,6,'h66, 0,'h5A,0,'h11,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    1,'hAA,0,'h11,0));
        tbl.push_back(mk(0, 1,0,6,0,    1,0,5,0,    0,'hAA,1,'hAA,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    0,'hAA,0,'hAA,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    1,'h66,0,'hAA,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    0,'h66,1,'h55,0));
        tbl.push_back(mk(0, 0,0,0,0,    0,0,0,0,    0,'h66,0,'h55,0));
        // d1: mismatched write latencies collide, write-first RDW and ordering
        tbl.push_back(mk(1, 1,1,1,'hA1, 1,1,2,'h00, 0,'h00,0,'h00,0));
        tbl.push_back(mk(1, 0,0,0,0,    0,0,0,0,    0,'h00,0,'h00,0));
        tbl.push_back(mk(1, 0,0,0,0,    0,0,0,0,    0,'h00,0,'h00,0));
        tbl.push_back(mk(1, 0,0,0,0,    1,1,1,'hB1, 0,'h00,0,'h00,1));
        tbl.push_back(mk(1, 1,0,1,0,    1,0,1,0,    1,'hA1,1,'hA1,0));
        tbl.push_back(mk(1, 1,1,2,'h11, 0,0,0,0,    0,'hA1,0,'hA1,0));
        tbl.push_back(mk(1, 0,0,0,0,    0,0,0,0,    0,'hA1,0,'hA1,0));
        tbl.push_back(mk(1, 0,0,0,0,    1,0,2,0,    0,'hA1,1,'h00,0));
        tbl.push_back(mk(1, 1,0,2,0,    1,0,2,0,    1,'h11,1,'h11,0));
        tbl.push_back(mk(1, 1,0,3,0,    1,1,3,'h22, 1,'h22,0,'h11,0));
        tbl.push_back(mk(1, 0,0,0,0,    0,0,0,0,    0,'h22,0,'h11,0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset d%0d dout_a", d), 64'(dout_a[d]), 64'h0);
            chk($sformatf("reset d%0d dout_b", d), 64'(dout_b[d]), 64'h0);
            chk($sformatf("reset d%0d rvalid_a", d), 64'(rvalid_a[d]), 64'h0);
            chk($sformatf("reset d%0d rvalid_b", d), 64'(rvalid_b[d]), 64'h0);
`ifdef DPRAM_COLLISION_FLAG_EN
            chk($sformatf("reset d%0d coll", d), 64'(coll[d]), 64'h0);
`endif
        end
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].d, tbl[i].ea, tbl[i].wa, tbl[i].aa, tbl[i].da,
                  tbl[i].eb, tbl[i].wb, tbl[i].ab, tbl[i].db);
            step();
            chk($sformatf("row%0d rvalid_a", i), 64'(rvalid_a[tbl[i].d]), 64'(tbl[i].xrva));
            chk($sformatf("row%0d dout_a", i), 64'(dout_a[tbl[i].d]), 64'(tbl[i].xda));
            chk($sformatf("row%0d rvalid_b", i), 64'(rvalid_b[tbl[i].d]), 64'(tbl[i].xrvb));
            chk($sformatf("row%0d dout_b", i), 64'(dout_b[tbl[i].d]), 64'(tbl[i].xdb));
`ifdef DPRAM_COLLISION_FLAG_EN
            chk($sformatf("row%0d coll", i), 64'(coll[tbl[i].d]), 64'(tbl[i].xcoll));
`endif
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-flight on d0: in-flight B read and pending A write are dropped
        drive(0, 1, 1, 3, 'h33, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 5, 0);
        step();
        chk("midrst rvalid_b r0", 64'(rvalid_b[0]), 64'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 1, 3, 'h99, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst async dout_b", 64'(dout_b[0]), 64'h0);
        chk("midrst async rvalid_b", 64'(rvalid_b[0]), 64'h0);
        chk("midrst async dout_a", 64'(dout_a[0]), 64'h0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("midrst no rvalid_b c%0d", k), 64'(rvalid_b[0]), 64'h0);
            chk($sformatf("midrst dout_b c%0d", k), 64'(dout_b[0]), 64'h0);
        end
        drive(0, 1, 0, 3, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("midrst readback rvalid_a", 64'(rvalid_a[0]), 64'h1);
        chk("midrst readback addr3", 64'(dout_a[0]), 64'h33);

        // Back-to-back bursts on every port of both configurations
        b2b(0, 1'b0, 'h40, 3);
        b2b(0, 1'b1, 'h80, 4);
        b2b(1, 1'b0, 'hC0, 1);
        b2b(1, 1'b1, 'h10, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
